// File: rtl/sum_unmask_decoder.sv
// Two-stage pipelined decoder: unmasks (in1 + in2) XOR key, subtracts the known addend
// in1 to recover in2, flags impossible sums, and keeps delivery statistics.
module sum_unmask_decoder #(
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             io_in_valid,
    output logic             io_in_ready,
    input  logic [32:0]      io_in_masked,
    input  logic [32:0]      io_in_key,
    input  logic [31:0]      io_in_known,
    output logic             io_out_valid,
    input  logic             io_out_ready,
    output logic [31:0]      io_out_recovered,
    output logic             io_out_err,
    output logic [CNT_W-1:0] io_good_count,
    output logic             io_err_sticky
);

    // Returns {err, recovered}; bit 33 of the difference is the borrow (sum < known),
    // bit 32 means the difference does not fit in 32 bits.
    function automatic logic [32:0] decode_word(input logic [32:0] sum, input logic [31:0] known);
        logic [33:0] diff;
        diff = {1'b0, sum} - {2'b00, known};
        return {diff[33] | diff[32], diff[31:0]};
    endfunction

    logic             s1_valid_r;
    logic [32:0]      s1_sum_r;
    logic [31:0]      s1_known_r;
    logic             s2_valid_r;
    logic [31:0]      s2_recovered_r;
    logic             s2_err_r;
    logic [CNT_W-1:0] good_count_r;
    logic             err_sticky_r;

    logic             out_fire_s;
    logic             s2_load_s;
    logic             s1_adv_s;
    logic             in_fire_s;
    logic [32:0]      decoded_s;

    // Handshake and advance conditions for both pipeline stages.
    always_comb begin
        out_fire_s = 1'b0;
        s2_load_s  = 1'b0;
        s1_adv_s   = 1'b0;
        in_fire_s  = 1'b0;
        decoded_s  = decode_word(s1_sum_r, s1_known_r);
        if (s2_valid_r) begin
            out_fire_s = io_out_ready;
        end else begin
            out_fire_s = 1'b0;
        end
        s2_load_s = ~s2_valid_r | out_fire_s;
        s1_adv_s  = ~s1_valid_r | s2_load_s;
        in_fire_s = io_in_valid & s1_adv_s;
    end

    // Pipeline valid bits; a reset drops every in-flight word.
    always_ff @(posedge clock) begin
        if (reset) begin
            s1_valid_r <= 1'b0;
            s2_valid_r <= 1'b0;
        end else begin
            if (s1_adv_s) begin
                s1_valid_r <= io_in_valid;
            end
            if (s2_load_s) begin
                s2_valid_r <= s1_valid_r;
            end
        end
    end

    // Pipeline data registers; contents are don't-care while the matching valid is low.
    always_ff @(posedge clock) begin
        if (in_fire_s) begin
            s1_sum_r   <= io_in_masked ^ io_in_key;
            s1_known_r <= io_in_known;
        end
        if (s2_load_s) begin
            s2_err_r       <= decoded_s[32];
            s2_recovered_r <= decoded_s[31:0];
        end
    end

    // Delivery statistics, updated only on output transfers.
    always_ff @(posedge clock) begin
        if (reset) begin
            good_count_r <= {CNT_W{1'b0}};
            err_sticky_r <= 1'b0;
        end else if (out_fire_s) begin
            if (s2_err_r) begin
                err_sticky_r <= 1'b1;
            end else if (good_count_r != {CNT_W{1'b1}}) begin
                good_count_r <= good_count_r + CNT_W'(1);
            end
        end
    end

    assign io_in_ready      = s1_adv_s;
    assign io_out_valid     = s2_valid_r;
    assign io_out_recovered = s2_recovered_r;
    assign io_out_err       = s2_err_r;
    assign io_good_count    = good_count_r;
    assign io_err_sticky    = err_sticky_r;

endmodule

// File: tb/tb_sum_unmask_decoder.sv
// Directed bench for sum_unmask_decoder: decode values, boundaries, backpressure,
// counter saturation (second instance with a 2-bit counter) and mid-stream reset.
module tb_sum_unmask_decoder;

    logic        clock;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [32:0] in_masked;
    logic [32:0] in_key;
    logic [31:0] in_known;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_recovered;
    logic        out_err;
    logic [15:0] good_count;
    logic        err_sticky;

    logic        sat_in_ready;
    logic        sat_out_valid;
    logic [31:0] sat_out_recovered;
    logic        sat_out_err;
    logic [1:0]  sat_good_count;
    logic        sat_err_sticky;

    int checks = 0;
    int errors = 0;
    int sent;
    int recv;
    logic in_fire;
    logic out_fire;

    sum_unmask_decoder dut (
        .clock(clock), .reset(reset),
        .io_in_valid(in_valid), .io_in_ready(in_ready),
        .io_in_masked(in_masked), .io_in_key(in_key), .io_in_known(in_known),
        .io_out_valid(out_valid), .io_out_ready(out_ready),
        .io_out_recovered(out_recovered), .io_out_err(out_err),
        .io_good_count(good_count), .io_err_sticky(err_sticky)
    );

    sum_unmask_decoder #(.CNT_W(2)) dut_sat (
        .clock(clock), .reset(reset),
        .io_in_valid(in_valid), .io_in_ready(sat_in_ready),
        .io_in_masked(in_masked), .io_in_key(in_key), .io_in_known(in_known),
        .io_out_valid(sat_out_valid), .io_out_ready(out_ready),
        .io_out_recovered(sat_out_recovered), .io_out_err(sat_out_err),
        .io_good_count(sat_good_count), .io_err_sticky(sat_err_sticky)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [32:0] masked, input logic [32:0] key,
                         input logic [31:0] known);
        in_valid  = v;
        in_masked = masked;
        in_key    = key;
        in_known  = known;
    endtask

    // Backpressure words: key 0, known = i, recovered = 0x100*(i+1).
    function automatic logic [32:0] bp_masked(input int i);
        return 33'(32'h100 * (i + 1) + i);
    endfunction

    initial begin
        reset = 1'b1;
        out_ready = 1'b1;
        drive(1'b0, 33'h0, 33'h0, 32'h0);
        tick();
        tick();
        reset = 1'b0;
        #1;
        chk("post_reset_in_ready", 64'(in_ready), 64'd1);
        chk("post_reset_out_valid", 64'(out_valid), 64'd0);
        chk("post_reset_good_count", 64'(good_count), 64'd0);
        chk("post_reset_sticky", 64'(err_sticky), 64'd0);

        // Nominal: sum = 0xC, known 5 -> 7.
        drive(1'b1, 33'h1_0000_000F, 33'h1_0000_0003, 32'd5);
        tick();
        drive(1'b0, 33'h0, 33'h0, 32'h0);
        chk("nominal_not_early", 64'(out_valid), 64'd0);
        tick();
        chk("nominal_valid", 64'(out_valid), 64'd1);
        chk("nominal_recovered", 64'(out_recovered), 64'd7);
        chk("nominal_err", 64'(out_err), 64'd0);
        tick();
        chk("nominal_good_count", 64'(good_count), 64'd1);
        chk("nominal_drained", 64'(out_valid), 64'd0);

        // Underflow: 3 - 5.
        drive(1'b1, 33'h0_0000_0003, 33'h0, 32'd5);
        tick();
        drive(1'b0, 33'h0, 33'h0, 32'h0);
        tick();
        chk("underflow_recovered", 64'(out_recovered), 64'hFFFF_FFFE);
        chk("underflow_err", 64'(out_err), 64'd1);
        tick();
        chk("underflow_sticky", 64'(err_sticky), 64'd1);
        chk("underflow_good_count", 64'(good_count), 64'd1);

        // Boundaries, back to back.
        drive(1'b1, 33'h1_FFFF_FFFE, 33'h0, 32'hFFFF_FFFF);
        tick();
        drive(1'b1, 33'h1_0000_0000, 33'h0, 32'h0);
        tick();
        drive(1'b0, 33'h0, 33'h0, 32'h0);
        chk("bound_max_valid", 64'(out_valid), 64'd1);
        chk("bound_max_recovered", 64'(out_recovered), 64'hFFFF_FFFF);
        chk("bound_max_err", 64'(out_err), 64'd0);
        tick();
        chk("bound_over_valid", 64'(out_valid), 64'd1);
        chk("bound_over_recovered", 64'(out_recovered), 64'd0);
        chk("bound_over_err", 64'(out_err), 64'd1);
        tick();
        chk("bound_good_count", 64'(good_count), 64'd2);
        chk("bound_drained", 64'(out_valid), 64'd0);

        // Backpressure: 4 words, out_ready low for the first 5 cycles.
        sent = 0;
        recv = 0;
        for (int cyc = 0; cyc < 30 && recv < 4; cyc++) begin
            if (sent < 4) drive(1'b1, bp_masked(sent), 33'h0, 32'(sent));
            else drive(1'b0, 33'h0, 33'h0, 32'h0);
            out_ready = (cyc >= 5);
            #1;
            if (cyc == 1) chk("bp_ready_after_one", 64'(in_ready), 64'd1);
            if (cyc >= 2 && cyc <= 4) begin
                chk("bp_ready_dropped", 64'(in_ready), 64'd0);
                chk("bp_accepted", 64'(sent), 64'd2);
                chk("bp_hold_valid", 64'(out_valid), 64'd1);
                chk("bp_hold_recovered", 64'(out_recovered), 64'h100);
            end
            in_fire  = in_valid & in_ready;
            out_fire = out_valid & out_ready;
            if (out_fire) begin
                chk("bp_order_recovered", 64'(out_recovered), 64'(32'h100 * (recv + 1)));
                chk("bp_order_err", 64'(out_err), 64'd0);
            end
            tick();
            if (in_fire) sent++;
            if (out_fire) recv++;
        end
        drive(1'b0, 33'h0, 33'h0, 32'h0);
        out_ready = 1'b1;
        chk("bp_all_delivered", 64'(recv), 64'd4);
        tick();
        chk("bp_no_extra", 64'(out_valid), 64'd0);
        chk("bp_good_count", 64'(good_count), 64'd6);

        // Saturation: restart, 5 good words; the 2-bit counter stops at 3.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        chk("sat_reset_count", 64'(sat_good_count), 64'd0);
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, bp_masked(i), 33'h0, 32'(i));
            tick();
        end
        drive(1'b0, 33'h0, 33'h0, 32'h0);
        tick();
        tick();
        tick();
        chk("sat_wide_count", 64'(good_count), 64'd5);
        chk("sat_narrow_count", 64'(sat_good_count), 64'd3);
        chk("sat_sticky", 64'(sat_err_sticky), 64'd0);

        // Mid-stream reset with two words in flight (one errored word also queued earlier).
        out_ready = 1'b0;
        drive(1'b1, 33'h0_0000_0001, 33'h0, 32'd2);
        tick();
        drive(1'b1, bp_masked(0), 33'h0, 32'd0);
        tick();
        drive(1'b0, 33'h0, 33'h0, 32'h0);
        chk("flight_valid", 64'(out_valid), 64'd1);
        chk("flight_in_ready", 64'(in_ready), 64'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_good_count", 64'(good_count), 64'd0);
        chk("rst_sat_count", 64'(sat_good_count), 64'd0);
        chk("rst_sticky", 64'(err_sticky), 64'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_nothing_emerges", 64'(out_valid), 64'd0);
        end
        chk("rst_count_still_zero", 64'(good_count), 64'd0);
        chk("rst_sticky_still_zero", 64'(err_sticky), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
